redstone_cmd_ctrl: RTL and testbench
====================================

Name: redstone_cmd_ctrl

Overview:
UART command controller that sequences the redstone simulation core. Decodes command bytes from the UART receiver and loads the simulation input vector. Gates the simulation tick for run, halt and single-step. Snapshots the output vector and streams it out through the UART transmitter. Sits between the uart_receive/uart_transmit pair and the redstone core, replacing the ad-hoc command FSM in the top level.

Parameters:
NUM_INPUTS, 10, width of simulation input vector; NUM_IN_BYTES = ceil(NUM_INPUTS/8)
NUM_OUTPUTS, 16, width of simulation output vector; NUM_OUT_BYTES = ceil(NUM_OUTPUTS/8)
TIMEOUT, 1000000, max i_clk cycles between payload bytes before abort; counter width $clog2(TIMEOUT+1)

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous, active-low reset
i_rx_valid  in  1  one-cycle pulse: i_rx_data holds a new received byte
i_rx_data  in  8  received byte
i_tx_ready  in  1  transmitter idle, may accept a byte
i_tx_done  in  1  one-cycle pulse: byte fully transmitted
o_tx_start  out  1  one-cycle pulse: launch o_tx_data
o_tx_data  out  8  byte to transmit; held stable until i_tx_done
i_outputs  in  NUM_OUTPUTS  live simulation outputs
o_inputs  out  NUM_INPUTS  registered simulation inputs
i_tick_pulse  in  1  one-cycle pulse per simulation tick, already in i_clk domain
o_tick_en  out  1  tick gate to the tick generator
o_busy  out  1  high in any state other than IDLE/RUN-idle
o_overrun  out  1  sticky: a byte was dropped or a payload timed out

Behaviour:
- Reset (i_rst low, async): o_inputs=0, o_tick_en=0, o_tx_start=0, o_tx_data=0, o_busy=0, o_overrun=0, state IDLE, all counters 0.
- Commands (first byte in IDLE):
  - 0x01 SEND_OUTPUTS: capture i_outputs into snapshot on the cycle the command is accepted. Go TX_LOAD with count=NUM_OUT_BYTES.
  - 0x02 SET_INPUTS: go RX_PAYLOAD, expecting NUM_IN_BYTES bytes, LSB byte first, into a shadow register. On the last byte, o_inputs <= shadow[NUM_INPUTS-1:0] in the next cycle (atomic; bits above NUM_INPUTS discarded).
  - 0x03 RUN: o_tick_en=1 next cycle; stay IDLE.
  - 0x04 HALT: o_tick_en=0 next cycle.
  - 0x05 STEP: RX_PAYLOAD for 1 byte N.
    - N=0: return to IDLE, no ticks.
    - Otherwise STEP_RUN: o_tick_en=1, count i_tick_pulse. o_tick_en drops in the cycle after the Nth pulse, then IDLE. Any free-run state is cleared at the end of the step.
  - Other codes: ignored (no state change).
- RX_PAYLOAD: a timeout counter resets on each byte. If it reaches TIMEOUT: discard the partial payload, set o_overrun, return to IDLE; o_inputs unchanged.
- TX_LOAD: wait for i_tx_ready. Then o_tx_data = snapshot byte (NUM_OUT_BYTES-count), LSB byte first; pad bits above NUM_OUTPUTS with 0. Pulse o_tx_start for 1 cycle, go TX_WAIT.
- TX_WAIT: on i_tx_done, decrement count. If count reaches 0, go IDLE; else TX_LOAD. Snapshot is never updated mid-stream.
- Bytes arriving in TX_LOAD/TX_WAIT are dropped and set o_overrun.
- Bytes arriving in STEP_RUN: 0x04 HALT aborts the step (o_tick_en=0, IDLE). Any other byte is dropped and sets o_overrun.
- i_rx_valid and i_tick_pulse in the same cycle: both processed.
- Reset mid-operation: immediate return to reset values; any partial tx byte is abandoned (transmitter has its own reset).
- Tick source must space i_tick_pulse at least 2 i_clk cycles apart so that exactly N ticks occur per STEP.

Optional Feature:
Macro REDSTONE_CMD_ACK_EN.
- Defined:
  - After SET_INPUTS apply, after STEP completion (including N=0 and HALT abort), and after RUN/HALT, send one ack byte 0xAA via the TX_LOAD/TX_WAIT path.
  - Unknown commands and payload timeouts send 0xEE.
  - Bytes received during an ack send are dropped and set o_overrun.
- Undefined: no ack or nak bytes; behaviour is exactly as above.

Test Plan:
1. Reset, i_outputs=16'hBEEF, rx 0x01 -> tx bytes 0xEF then 0xBE, o_tx_start pulsed exactly twice, then IDLE and o_busy=0.
2. rx 0x02,0x55,0x03 (NUM_INPUTS=10) -> o_inputs stays 0 until the last byte, then becomes 10'h355 in one cycle.
3. rx 0x05,0x03 with ticks every 10 cycles -> exactly 3 i_tick_pulse seen while o_tick_en=1; o_tick_en=0 one cycle after the 3rd.
4. rx 0x02,0x12 then silence > TIMEOUT (TIMEOUT=100 in bench) -> o_overrun=1, o_inputs unchanged, next 0x01 is serviced normally.
5. During SEND_OUTPUTS, change i_outputs between bytes and inject rx 0x03 -> transmitted bytes match the original snapshot, o_overrun=1, o_tick_en stays 0.
6. rx 0x05,0xFF, then 0x04 after 5 ticks -> o_tick_en drops the next cycle, state IDLE, no further ticks counted; (ACK_EN) tx 0xAA.

Source files
------------

// File: rtl/redstone_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// redstone_cmd_ctrl
//
// UART command controller for the redstone simulation core. It decodes
// command bytes from the UART receiver, loads the simulation input vector,
// gates the simulation tick (run / halt / single-step), and streams a
// snapshot of the simulation outputs back through the UART transmitter.
//
// Commands (first byte while idle):
//   0x01 SEND_OUTPUTS  snapshot i_outputs, transmit LSB byte first
//   0x02 SET_INPUTS    receive NUM_IN_BYTES bytes (LSB first), apply atomically
//   0x03 RUN           free-run tick enable on
//   0x04 HALT          tick enable off (also aborts an active step)
//   0x05 STEP          receive count N, enable ticks for exactly N tick pulses
//   others             ignored
//
// Optional build macro: REDSTONE_CMD_ACK_EN
//   When defined, completed commands send 0xAA and unknown commands /
//   payload timeouts send 0xEE through the transmit path.
//
// Ports:
//   i_clk        system clock
//   i_rst        asynchronous active-low reset
//   i_rx_valid   one-cycle pulse, i_rx_data holds a received byte
//   i_rx_data    received byte
//   i_tx_ready   transmitter idle, may accept a byte
//   i_tx_done    one-cycle pulse, byte fully transmitted
//   o_tx_start   one-cycle pulse, launch o_tx_data
//   o_tx_data    byte to transmit, held until i_tx_done
//   i_outputs    live simulation outputs
//   o_inputs     registered simulation inputs
//   i_tick_pulse one pulse per simulation tick (i_clk domain)
//   o_tick_en    tick gate to the tick generator
//   o_busy       high whenever the controller is not idle
//   o_overrun    sticky: a byte was dropped or a payload timed out
// ---------------------------------------------------------------------------
module redstone_cmd_ctrl #(
   parameter int NUM_INPUTS  = 10,
   parameter int NUM_OUTPUTS = 16,
   parameter int TIMEOUT     = 1000000
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_rx_valid,
   input  logic [7:0]             i_rx_data,
   input  logic                   i_tx_ready,
   input  logic                   i_tx_done,
   output logic                   o_tx_start,
   output logic [7:0]             o_tx_data,
   input  logic [NUM_OUTPUTS-1:0] i_outputs,
   output logic [NUM_INPUTS-1:0]  o_inputs,
   input  logic                   i_tick_pulse,
   output logic                   o_tick_en,
   output logic                   o_busy,
   output logic                   o_overrun
);

   localparam int NUM_IN_BYTES  = (NUM_INPUTS + 7) / 8;
   localparam int NUM_OUT_BYTES = (NUM_OUTPUTS + 7) / 8;
   localparam int TO_W          = $clog2(TIMEOUT + 1);
   localparam int CNT_W         = 8;

   localparam logic [7:0] CMD_SEND = 8'h01;
   localparam logic [7:0] CMD_SET  = 8'h02;
   localparam logic [7:0] CMD_RUN  = 8'h03;
   localparam logic [7:0] CMD_HALT = 8'h04;
   localparam logic [7:0] CMD_STEP = 8'h05;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RX_PAYLOAD,
      ST_STEP_RUN,
      ST_TX_LOAD,
      ST_TX_WAIT
   } state_t;

   state_t                     state_reg, state_next;
   logic [CNT_W-1:0]           idx_reg, idx_next;          // payload / tx byte index
   logic [7:0]                 tick_cnt_reg, tick_cnt_next; // ticks remaining in step
   logic [TO_W-1:0]            to_cnt_reg, to_cnt_next;
   logic [NUM_IN_BYTES*8-1:0]  shadow_reg, shadow_next;
   logic [NUM_OUT_BYTES*8-1:0] snapshot_reg, snapshot_next;
   logic [NUM_INPUTS-1:0]      inputs_reg, inputs_next;
   logic                       tick_en_reg, tick_en_next;
   logic                       tx_start_reg, tx_start_next;
   logic [7:0]                 tx_data_reg, tx_data_next;
   logic                       overrun_reg, overrun_next;
   logic                       is_step_reg, is_step_next;  // payload belongs to STEP
   logic                       ack_req, nak_req;
`ifdef REDSTONE_CMD_ACK_EN
   logic                       ack_reg, ack_next;          // tx path carries an ack byte
   logic [7:0]                 ack_byte_reg, ack_byte_next;
`endif

   // Payload byte written into the shadow at the current index, and the
   // snapshot byte selected by the current index. Built as constant-index
   // muxes so no variable part-selects are needed.
   logic [NUM_IN_BYTES*8-1:0]      shadow_wr;
   logic [(NUM_OUT_BYTES+1)*8-1:0] tx_or;
   logic [7:0]                     tx_byte;

   assign tx_or[7:0] = 8'h00;

   generate
      for (genvar gi = 0; gi < NUM_IN_BYTES; gi++) begin : g_shadow
         assign shadow_wr[gi*8 +: 8] = (idx_reg == CNT_W'(gi)) ? i_rx_data
                                                               : shadow_reg[gi*8 +: 8];
      end
      for (genvar gi = 0; gi < NUM_OUT_BYTES; gi++) begin : g_txsel
         assign tx_or[(gi+1)*8 +: 8] = tx_or[gi*8 +: 8] |
                                       ((idx_reg == CNT_W'(gi)) ? snapshot_reg[gi*8 +: 8]
                                                                : 8'h00);
      end
   endgenerate

   assign tx_byte = tx_or[NUM_OUT_BYTES*8 +: 8];

   // State register
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_reg    <= ST_IDLE;
         idx_reg      <= '0;
         tick_cnt_reg <= '0;
         to_cnt_reg   <= '0;
         shadow_reg   <= '0;
         snapshot_reg <= '0;
         inputs_reg   <= '0;
         tick_en_reg  <= 1'b0;
         tx_start_reg <= 1'b0;
         tx_data_reg  <= 8'h00;
         overrun_reg  <= 1'b0;
         is_step_reg  <= 1'b0;
`ifdef REDSTONE_CMD_ACK_EN
         ack_reg      <= 1'b0;
         ack_byte_reg <= 8'h00;
`endif
      end else begin
         state_reg    <= state_next;
         idx_reg      <= idx_next;
         tick_cnt_reg <= tick_cnt_next;
         to_cnt_reg   <= to_cnt_next;
         shadow_reg   <= shadow_next;
         snapshot_reg <= snapshot_next;
         inputs_reg   <= inputs_next;
         tick_en_reg  <= tick_en_next;
         tx_start_reg <= tx_start_next;
         tx_data_reg  <= tx_data_next;
         overrun_reg  <= overrun_next;
         is_step_reg  <= is_step_next;
`ifdef REDSTONE_CMD_ACK_EN
         ack_reg      <= ack_next;
         ack_byte_reg <= ack_byte_next;
`endif
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      logic tx_last;
      state_next    = state_reg;
      idx_next      = idx_reg;
      tick_cnt_next = tick_cnt_reg;
      to_cnt_next   = to_cnt_reg;
      shadow_next   = shadow_reg;
      snapshot_next = snapshot_reg;
      inputs_next   = inputs_reg;
      tick_en_next  = tick_en_reg;
      tx_start_next = 1'b0;
      tx_data_next  = tx_data_reg;
      overrun_next  = overrun_reg;
      is_step_next  = is_step_reg;
      ack_req       = 1'b0;
      nak_req       = 1'b0;
      tx_last       = (idx_reg == CNT_W'(NUM_OUT_BYTES - 1));
`ifdef REDSTONE_CMD_ACK_EN
      ack_next      = ack_reg;
      ack_byte_next = ack_byte_reg;
      tx_last       = tx_last | ack_reg;
`endif

      case (state_reg)
         ST_IDLE: begin
            if (i_rx_valid) begin
               case (i_rx_data)
                  CMD_SEND: begin
                     snapshot_next                  = '0;
                     snapshot_next[NUM_OUTPUTS-1:0] = i_outputs;
                     idx_next                       = '0;
                     state_next                     = ST_TX_LOAD;
                  end
                  CMD_SET: begin
                     is_step_next = 1'b0;
                     idx_next     = '0;
                     to_cnt_next  = '0;
                     state_next   = ST_RX_PAYLOAD;
                  end
                  CMD_RUN: begin
                     tick_en_next = 1'b1;
                     ack_req      = 1'b1;
                  end
                  CMD_HALT: begin
                     tick_en_next = 1'b0;
                     ack_req      = 1'b1;
                  end
                  CMD_STEP: begin
                     is_step_next = 1'b1;
                     idx_next     = '0;
                     to_cnt_next  = '0;
                     state_next   = ST_RX_PAYLOAD;
                  end
                  default: nak_req = 1'b1;
               endcase
            end
         end

         ST_RX_PAYLOAD: begin
            if (i_rx_valid) begin
               to_cnt_next = '0;
               if (is_step_reg) begin
                  if (i_rx_data == 8'h00) begin
                     // Zero-length step: finishes at once, ending any free run.
                     tick_en_next = 1'b0;
                     state_next   = ST_IDLE;
                     ack_req      = 1'b1;
                  end else begin
                     tick_cnt_next = i_rx_data;
                     tick_en_next  = 1'b1;
                     state_next    = ST_STEP_RUN;
                  end
               end else begin
                  shadow_next = shadow_wr;
                  if (idx_reg == CNT_W'(NUM_IN_BYTES - 1)) begin
                     // Whole vector applied in one edge; pad bits are dropped.
                     inputs_next = shadow_wr[NUM_INPUTS-1:0];
                     idx_next    = '0;
                     state_next  = ST_IDLE;
                     ack_req     = 1'b1;
                  end else begin
                     idx_next = idx_reg + 1'b1;
                  end
               end
            end else if (to_cnt_reg == TO_W'(TIMEOUT)) begin
               overrun_next = 1'b1;
               idx_next     = '0;
               state_next   = ST_IDLE;
               nak_req      = 1'b1;
            end else begin
               to_cnt_next = to_cnt_reg + 1'b1;
            end
         end

         ST_STEP_RUN: begin
            if (i_rx_valid && i_rx_data == CMD_HALT) begin
               tick_en_next = 1'b0;
               state_next   = ST_IDLE;
               ack_req      = 1'b1;
            end else begin
               if (i_rx_valid) begin
                  overrun_next = 1'b1;
               end
               if (i_tick_pulse) begin
                  if (tick_cnt_reg == 8'd1) begin
                     tick_en_next = 1'b0;
                     state_next   = ST_IDLE;
                     ack_req      = 1'b1;
                  end else begin
                     tick_cnt_next = tick_cnt_reg - 1'b1;
                  end
               end
            end
         end

         ST_TX_LOAD: begin
            if (i_rx_valid) begin
               overrun_next = 1'b1;
            end
            if (i_tx_ready) begin
`ifdef REDSTONE_CMD_ACK_EN
               tx_data_next = ack_reg ? ack_byte_reg : tx_byte;
`else
               tx_data_next = tx_byte;
`endif
               tx_start_next = 1'b1;
               state_next    = ST_TX_WAIT;
            end
         end

         ST_TX_WAIT: begin
            if (i_rx_valid) begin
               overrun_next = 1'b1;
            end
            if (i_tx_done) begin
               if (tx_last) begin
                  idx_next   = '0;
                  state_next = ST_IDLE;
`ifdef REDSTONE_CMD_ACK_EN
                  ack_next   = 1'b0;
`endif
               end else begin
                  idx_next   = idx_reg + 1'b1;
                  state_next = ST_TX_LOAD;
               end
            end
         end

         default: state_next = ST_IDLE;
      endcase

      // Completion of a command: either report through the tx path or
      // simply settle back to idle.
`ifdef REDSTONE_CMD_ACK_EN
      if (ack_req || nak_req) begin
         state_next    = ST_TX_LOAD;
         ack_next      = 1'b1;
         ack_byte_next = nak_req ? 8'hEE : 8'hAA;
      end
`else
      if (ack_req || nak_req) begin
         state_next = ST_IDLE;
      end
`endif
   end

   assign o_tx_start = tx_start_reg;
   assign o_tx_data  = tx_data_reg;
   assign o_inputs   = inputs_reg;
   assign o_tick_en  = tick_en_reg;
   assign o_busy     = (state_reg != ST_IDLE);
   assign o_overrun  = overrun_reg;

endmodule

// File: tb/tb_redstone_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// Directed testbench for redstone_cmd_ctrl (NUM_INPUTS=10, NUM_OUTPUTS=16,
// TIMEOUT=100). A simple transmitter model logs every launched byte and a
// gated tick generator pulses every 10 cycles while o_tick_en is high.
// ---------------------------------------------------------------------------
module tb_redstone_cmd_ctrl;

   logic        clk;
   logic        rst_n;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        tx_ready;
   logic        tx_done;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic [15:0] sim_outputs;
   logic [9:0]  sim_inputs;
   logic        tick_pulse;
   logic        tick_en;
   logic        busy;
   logic        overrun;

   int          errors = 0;
   int          checks = 0;
   logic [7:0]  tx_log[$];
   int          start_cnt = 0;
   int          tx_busy_cnt = 0;
   int          tick_ph = 0;
   int          tick_seen = 0;

   redstone_cmd_ctrl #(
      .NUM_INPUTS (10),
      .NUM_OUTPUTS(16),
      .TIMEOUT    (100)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst_n),
      .i_rx_valid  (rx_valid),
      .i_rx_data   (rx_data),
      .i_tx_ready  (tx_ready),
      .i_tx_done   (tx_done),
      .o_tx_start  (tx_start),
      .o_tx_data   (tx_data),
      .i_outputs   (sim_outputs),
      .o_inputs    (sim_inputs),
      .i_tick_pulse(tick_pulse),
      .o_tick_en   (tick_en),
      .o_busy      (busy),
      .o_overrun   (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Transmitter model: accepts a start, stays busy 4 cycles, pulses done.
   initial begin
      tx_ready = 1'b1;
      tx_done  = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (tx_done) begin
            tx_done  = 1'b0;
            tx_ready = 1'b1;
         end else if (tx_busy_cnt > 0) begin
            tx_busy_cnt = tx_busy_cnt - 1;
            if (tx_busy_cnt == 0) tx_done = 1'b1;
         end else if (tx_start) begin
            tx_log.push_back(tx_data);
            start_cnt   = start_cnt + 1;
            tx_ready    = 1'b0;
            tx_busy_cnt = 4;
         end
      end
   end

   // Tick generator: one pulse every 10 cycles while enabled.
   initial begin
      tick_pulse = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (tick_en) begin
            tick_ph = tick_ph + 1;
            if (tick_ph == 10) begin
               tick_pulse = 1'b1;
               tick_ph    = 0;
            end else begin
               tick_pulse = 1'b0;
            end
         end else begin
            tick_pulse = 1'b0;
            tick_ph    = 0;
         end
      end
   end

   // Watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         errors = errors + 1;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk);
      #1;
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      $display("rx byte %02h: busy=%0b tick_en=%0b inputs=%03h overrun=%0b",
               b, busy, tick_en, sim_inputs, overrun);
   endtask

   task automatic wait_idle(input string tag);
      for (int c = 0; c < 500; c++) begin
         if (busy === 1'b0) break;
         @(posedge clk);
         #1;
      end
      check(tag, 32'(busy), 32'd0);
   endtask

   task automatic clear_log();
      tx_log.delete();
      start_cnt = 0;
   endtask

   // Count enabled tick pulses on falling edges until target or budget.
   task automatic count_ticks(input int target, input int budget);
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (tick_pulse && tick_en) tick_seen = tick_seen + 1;
         if (tick_seen >= target) break;
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      rx_valid    = 1'b0;
      rx_data     = 8'h00;
      sim_outputs = 16'hBEEF;
      repeat (3) @(posedge clk);
      #1;
      // Reset state
      check("rst_tx_start", 32'(tx_start), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_inputs", 32'(sim_inputs), 32'd0);
      check("rst_tick_en", 32'(tick_en), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      rst_n = 1'b1;

      // 1: SEND_OUTPUTS with 0xBEEF
      clear_log();
      send_byte(8'h01);
      check("send_busy", 32'(busy), 32'd1);
      wait_idle("send_idle");
      check("send_count", 32'(start_cnt), 32'd2);
      check("send_b0", 32'(tx_log[0]), 32'h0EF);
      check("send_b1", 32'(tx_log[1]), 32'h0BE);
      $display("tx bytes: %0d first=%02h second=%02h", start_cnt, tx_log[0], tx_log[1]);

      // 2: SET_INPUTS 0x55, 0x03 -> 10'h355
      clear_log();
      send_byte(8'h02);
      check("set_hold0", 32'(sim_inputs), 32'd0);
      send_byte(8'h55);
      check("set_hold1", 32'(sim_inputs), 32'd0);
      send_byte(8'h03);
      check("set_apply", 32'(sim_inputs), 32'h355);
`ifdef REDSTONE_CMD_ACK_EN
      wait_idle("set_ack_idle");
      check("set_ack", 32'(tx_log[0]), 32'h0AA);
`endif

      // Unknown command is ignored
      clear_log();
      send_byte(8'h7F);
`ifdef REDSTONE_CMD_ACK_EN
      wait_idle("unk_idle");
      check("unk_nak", 32'(tx_log[0]), 32'h0EE);
`else
      check("unk_busy", 32'(busy), 32'd0);
`endif
      check("unk_tick_en", 32'(tick_en), 32'd0);

      // RUN / HALT
      send_byte(8'h03);
      check("run_tick_en", 32'(tick_en), 32'd1);
      wait_idle("run_idle");
      send_byte(8'h04);
      check("halt_tick_en", 32'(tick_en), 32'd0);
      wait_idle("halt_idle");

      // STEP with N=0: no ticks
      send_byte(8'h05);
      send_byte(8'h00);
      check("step0_tick_en", 32'(tick_en), 32'd0);
      wait_idle("step0_idle");

      // 3: STEP 3 ticks
      clear_log();
      tick_seen = 0;
      send_byte(8'h05);
      send_byte(8'h03);
      check("step3_en", 32'(tick_en), 32'd1);
      count_ticks(3, 200);
      @(negedge clk);
      check("step3_drop", 32'(tick_en), 32'd0);
      wait_idle("step3_idle");
      count_ticks(99, 40);
      check("step3_ticks", 32'(tick_seen), 32'd3);
      $display("step 3: ticks=%0d tick_en=%0b", tick_seen, tick_en);
`ifdef REDSTONE_CMD_ACK_EN
      check("step3_ack", 32'(tx_log[0]), 32'h0AA);
`endif

      // 4: payload timeout
      clear_log();
      send_byte(8'h02);
      send_byte(8'h12);
      repeat (150) @(posedge clk);
      #1;
      check("to_overrun", 32'(overrun), 32'd1);
      check("to_inputs", 32'(sim_inputs), 32'h355);
      check("to_busy", 32'(busy), 32'd0);
`ifdef REDSTONE_CMD_ACK_EN
      check("to_nak", 32'(tx_log[0]), 32'h0EE);
`endif
      clear_log();
      sim_outputs = 16'h1234;
      send_byte(8'h01);
      wait_idle("to_send_idle");
      check("to_send_b0", 32'(tx_log[0]), 32'h034);
      check("to_send_b1", 32'(tx_log[1]), 32'h012);

      // Asynchronous reset clears state immediately
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_inputs", 32'(sim_inputs), 32'd0);
      check("arst_overrun", 32'(overrun), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // 5: snapshot stable during stream, injected byte dropped
      clear_log();
      sim_outputs = 16'hA5C3;
      send_byte(8'h01);
      sim_outputs = 16'h0000;
      send_byte(8'h03);
      wait_idle("snap_idle");
      check("snap_count", 32'(start_cnt), 32'd2);
      check("snap_b0", 32'(tx_log[0]), 32'h0C3);
      check("snap_b1", 32'(tx_log[1]), 32'h0A5);
      check("snap_overrun", 32'(overrun), 32'd1);
      check("snap_tick_en", 32'(tick_en), 32'd0);

      // 6: STEP 255 aborted by HALT after 5 ticks
      clear_log();
      tick_seen = 0;
      send_byte(8'h05);
      send_byte(8'hFF);
      count_ticks(5, 300);
      check("abort_pre_ticks", 32'(tick_seen), 32'd5);
      send_byte(8'h04);
      check("abort_tick_en", 32'(tick_en), 32'd0);
`ifndef REDSTONE_CMD_ACK_EN
      check("abort_busy", 32'(busy), 32'd0);
`endif
      wait_idle("abort_idle");
      count_ticks(99, 40);
      check("abort_ticks", 32'(tick_seen), 32'd5);
`ifdef REDSTONE_CMD_ACK_EN
      check("abort_ack", 32'(tx_log[0]), 32'h0AA);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
